// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, transmitter and receive FIFO.
// Contents:
//   UART_DATA_WIDTH - character width on the serial line
//   baud constants  - 50 MHz board clock divided down to the line rate
//   fifo_state_t    - occupancy class of the receive FIFO
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;

    localparam int unsigned CLK_FREQ_HZ     = 50_000_000;
    localparam int unsigned BAUD_RATE       = 115_200;
    localparam int unsigned CLKS_PER_BIT    = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned RX_SAMPLE_POINT = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } fifo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO.
// Simple dual-port: one synchronous write port, one asynchronous read port, so
// it maps onto distributed RAM or plain registers. The array is never reset.
// Ports:
//   clk   - system clock
//   we    - write enable, writes wdata to waddr on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data at raddr
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer sitting directly behind the UART receiver.
// Each byte loaded by the receiver (wr_stb) is queued and presented
// first-word-fall-through on a valid/ready interface. Bytes arriving while the
// queue is full and not being drained are dropped and flagged in a sticky
// overflow bit.
// Ports:
//   clk          - system clock
//   rst          - synchronous active-high reset, discards queued bytes
//   wr_data      - byte from the receiver, sampled when wr_stb=1
//   wr_stb       - one-cycle load strobe from the receiver
//   rd_data      - head-of-queue byte, 0 when empty
//   rd_valid     - queue non-empty
//   rd_ready     - consumer accepts the head byte this cycle
//   count        - occupancy, 0..2**ADDR_WIDTH
//   full         - occupancy equals depth
//   almost_full  - occupancy at or above ALMOST_FULL_LEVEL
//   overflow     - sticky, a byte was dropped
//   clr_overflow - clears overflow (a coincident drop wins)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = UART_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH        = 4,
    parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_stb,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam int unsigned DEPTH_M1 = DEPTH - 1;

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   LAST_COUNT = DEPTH_M1[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AF_COUNT   = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  overflow_q;
    fifo_state_t           state_q;

    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Flags come straight from the registered count so they never lag occupancy.
    always_comb begin
        rd_valid    = (count_q != '0);
        full        = (count_q == FULL_COUNT);
        almost_full = (count_q >= AF_COUNT);
        pop         = rd_valid && rd_ready;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        push        = wr_stb && (!full || pop);
        drop        = wr_stb && full && !pop;
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // Storage is not reset, so mask stale contents while empty.
    assign rd_data  = rd_valid ? mem_rdata : '0;
    assign count    = count_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= EMPTY;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end

            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_q <= PARTIAL;
                    end
                end
                PARTIAL: begin
                    if (push && !pop && (count_q == LAST_COUNT)) begin
                        state_q <= FULL;
                    end else if (pop && !push && (count_q == COUNT_ONE)) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop && !push) begin
                        state_q <= PARTIAL;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_stb;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] count;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       clr_overflow;

    int vectors;
    int miscompares;
    logic [7:0] sb_q[$];
    logic       chk_en;
    fifo_state_t exp_state;

    uart_rx_fifo #(
        .DATA_WIDTH        (8),
        .ADDR_WIDTH        (4),
        .ALMOST_FULL_LEVEL (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_stb       (wr_stb),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .count        (count),
        .full         (full),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Internal state must always agree with occupancy.
    always @(negedge clk) begin
        if (chk_en) begin
            if (count == 5'd0)       exp_state = EMPTY;
            else if (count == 5'd16) exp_state = FULL;
            else                     exp_state = PARTIAL;
            vectors++;
            if (dut.state_q !== exp_state) begin
                miscompares++;
                $display("FAIL state_vs_count: state %0d count %0d, required state %0d",
                         dut.state_q, count, exp_state);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if ({rd_valid, count, rd_data, overflow, full, almost_full} !== 17'd0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: valid %b count %0d data %h ovf %b full %b af %b, required all zero",
                         i, rd_valid, count, rd_data, overflow, full, almost_full);
            end
        end
    endtask

    task automatic test_single();
        wr_data = 8'hA5;
        wr_stb  = 1'b1;
        sb_q.push_back(8'hA5);
        tick();
        wr_stb = 1'b0;
        vectors++;
        if ({rd_valid, rd_data, count} !== {1'b1, 8'hA5, 5'd1}) begin
            miscompares++;
            $display("FAIL single_push: valid %b data %h count %0d, required 1 a5 1",
                     rd_valid, rd_data, count);
        end
        rd_ready = 1'b1;
        void'(sb_q.pop_front());
        tick();
        rd_ready = 1'b0;
        vectors++;
        if ({rd_valid, count} !== {1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL single_pop: valid %b count %0d, required 0 0", rd_valid, count);
        end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i);
            wr_stb  = 1'b1;
            sb_q.push_back(8'(i));
            tick();
            vectors++;
            if ({count, almost_full, full} !== {5'(i + 1), (i + 1 >= 12), (i + 1 == 16)}) begin
                miscompares++;
                $display("FAIL fill step %0d: count %0d af %b full %b, required %0d %b %b",
                         i, count, almost_full, full, i + 1, (i + 1 >= 12), (i + 1 == 16));
            end
        end
        wr_data = 8'hFF;
        tick();
        wr_stb = 1'b0;
        vectors++;
        if ({overflow, count, full} !== {1'b1, 5'd16, 1'b1}) begin
            miscompares++;
            $display("FAIL fill_drop: ovf %b count %0d full %b, required 1 16 1",
                     overflow, count, full);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = sb_q.pop_front();
            vectors++;
            if ({rd_valid, rd_data} !== {1'b1, exp}) begin
                miscompares++;
                $display("FAIL fill_drain %0d: valid %b data %h, required 1 %h",
                         i, rd_valid, rd_data, exp);
            end
            tick();
        end
        rd_ready = 1'b0;
        vectors++;
        if ({rd_valid, count, rd_data, overflow} !== {1'b0, 5'd0, 8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL fill_empty: valid %b count %0d data %h ovf %b, required 0 0 00 1",
                     rd_valid, count, rd_data, overflow);
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_clear: ovf %b, required 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'h80 + 8'(i);
            wr_stb  = 1'b1;
            sb_q.push_back(8'h80 + 8'(i));
            tick();
        end
        wr_data  = 8'h55;
        rd_ready = 1'b1;
        exp = sb_q.pop_front();
        sb_q.push_back(8'h55);
        vectors++;
        if (rd_data !== exp) begin
            miscompares++;
            $display("FAIL fpp_head: data %h, required %h", rd_data, exp);
        end
        tick();
        wr_stb = 1'b0;
        vectors++;
        if ({count, overflow, full} !== {5'd16, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL fpp_count: count %0d ovf %b full %b, required 16 0 1",
                     count, overflow, full);
        end
        for (int i = 0; i < 16; i++) begin
            exp = sb_q.pop_front();
            vectors++;
            if ({rd_valid, rd_data} !== {1'b1, exp}) begin
                miscompares++;
                $display("FAIL fpp_drain %0d: valid %b data %h, required 1 %h",
                         i, rd_valid, rd_data, exp);
            end
            tick();
        end
        rd_ready = 1'b0;
        vectors++;
        if (count !== 5'd0) begin
            miscompares++;
            $display("FAIL fpp_empty: count %0d, required 0", count);
        end
    endtask

    task automatic test_overflow_clear();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'hC0 + 8'(i);
            wr_stb  = 1'b1;
            sb_q.push_back(8'hC0 + 8'(i));
            tick();
        end
        wr_data      = 8'hFF;
        clr_overflow = 1'b1;
        tick();
        wr_stb = 1'b0;
        vectors++;
        if ({overflow, count} !== {1'b1, 5'd16}) begin
            miscompares++;
            $display("FAIL ovf_set_wins: ovf %b count %0d, required 1 16", overflow, count);
        end
        tick();
        clr_overflow = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: ovf %b, required 0", overflow);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = sb_q.pop_front();
            vectors++;
            if (rd_data !== exp) begin
                miscompares++;
                $display("FAIL ovf_drain %0d: data %h, required %h", i, rd_data, exp);
            end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_no_bypass();
        wr_data  = 8'h77;
        wr_stb   = 1'b1;
        rd_ready = 1'b1;
        tick();
        wr_stb   = 1'b0;
        rd_ready = 1'b0;
        vectors++;
        if ({rd_valid, rd_data, count} !== {1'b1, 8'h77, 5'd1}) begin
            miscompares++;
            $display("FAIL no_bypass: valid %b data %h count %0d, required 1 77 1",
                     rd_valid, rd_data, count);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            wr_data = 8'h10 + 8'(i);
            wr_stb  = 1'b1;
            tick();
        end
        vectors++;
        if (count !== 5'd7) begin
            miscompares++;
            $display("FAIL rst_mid_fill: count %0d, required 7", count);
        end
        rst     = 1'b1;
        wr_data = 8'hEE;
        tick();
        rst    = 1'b0;
        wr_stb = 1'b0;
        vectors++;
        if ({count, rd_valid} !== {5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid: count %0d valid %b, required 0 0", count, rd_valid);
        end
        wr_data = 8'h3C;
        wr_stb  = 1'b1;
        tick();
        wr_stb = 1'b0;
        vectors++;
        if ({rd_data, count} !== {8'h3C, 5'd1}) begin
            miscompares++;
            $display("FAIL rst_first_byte: data %h count %0d, required 3c 1", rd_data, count);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] exp;
        logic       exp_ovf;
        logic       mpop;
        int         size_before;
        exp_ovf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            wr_stb       = 1'($urandom_range(0, 1));
            wr_data      = 8'($urandom);
            rd_ready     = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            size_before  = sb_q.size();
            mpop         = (size_before != 0) && rd_ready;
            if (mpop) begin
                exp = sb_q.pop_front();
                vectors++;
                if (rd_data !== exp) begin
                    miscompares++;
                    $display("FAIL rand_data cycle %0d: data %h, required %h", c, rd_data, exp);
                end
            end
            if (wr_stb && (size_before < 16 || mpop)) sb_q.push_back(wr_data);
            if (wr_stb && size_before == 16 && !mpop) exp_ovf = 1'b1;
            else if (clr_overflow)                    exp_ovf = 1'b0;
            tick();
            vectors++;
            if ({count, overflow, rd_valid} !== {5'(sb_q.size()), exp_ovf, sb_q.size() != 0}) begin
                miscompares++;
                $display("FAIL rand_flags cycle %0d: count %0d ovf %b valid %b, required %0d %b %b",
                         c, count, overflow, rd_valid, sb_q.size(), exp_ovf, sb_q.size() != 0);
            end
        end
        wr_stb       = 1'b0;
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        chk_en       = 1'b0;
        rst          = 1'b1;
        wr_data      = 8'h00;
        wr_stb       = 1'b0;
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_overflow_clear();
        test_no_bypass();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART receiver.
- Captures each completed byte on the receiver's one-cycle load strobe and holds it in a circular buffer.
- Presents bytes first-word-fall-through on a valid/ready interface to the consuming logic (command parser, LED/7-seg driver).
- Flags overflow when the consumer falls behind the line rate.

Parameters:
- DATA_WIDTH, 8, byte width; must match receiver data width.
- ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH (16).
- ALMOST_FULL_LEVEL, 12, occupancy at or above which almost_full asserts; legal range 1..2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock (50 MHz board clock).
- rst  in  1  reset.
- wr_data  in  DATA_WIDTH  byte from receiver; sampled only when wr_stb=1.
- wr_stb  in  1  one-cycle pulse; receiver has loaded a new byte.
- rd_data  out  DATA_WIDTH  head-of-queue byte; 0 when empty.
- rd_valid  out  1  queue non-empty; rd_data is meaningful.
- rd_ready  in  1  consumer accepts head byte this cycle.
- count  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- full  out  1  count == 2**ADDR_WIDTH.
- almost_full  out  1  count >= ALMOST_FULL_LEVEL.
- overflow  out  1  sticky: a byte was dropped.
- clr_overflow  in  1  clears overflow.

Behaviour:
- One clock; reset is synchronous and active-high: clk is the only clock; rst sampled on rising clk edge.
- Reset values:
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - rd_valid=0, rd_data=0, full=0, almost_full=0.
  - Storage array is not reset.
- Reset mid-operation discards all queued bytes. A wr_stb coincident with rst is ignored.
- Push: wr_stb=1 and (full=0 or pop this cycle).
  - mem[wr_ptr] <= wr_data; wr_ptr increments modulo 2**ADDR_WIDTH.
- Pop: rd_valid=1 and rd_ready=1.
  - rd_ptr increments modulo 2**ADDR_WIDTH.
  - rd_ready while rd_valid=0 has no effect.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged.
  - Full plus push-and-pop: write accepted, no overflow.
- Latency:
  - Byte pushed at edge N gives rd_valid=1 and rd_data=that byte from edge N onward (visible in cycle N+1).
  - No same-cycle bypass. When empty, wr_stb with rd_ready does not pop the incoming byte.
- Output decode:
  - rd_data = mem[rd_ptr] when count!=0, else 0.
  - rd_valid, full and almost_full are decoded from count; no extra cycle of lag.
- Overflow:
  - wr_stb=1, full=1 and no pop: byte dropped, all pointers unchanged, overflow <= 1.
  - overflow holds until clr_overflow=1.
  - Set and clear in the same cycle: set wins (overflow stays 1).
- Ordering is strict FIFO. Pointer wrap is transparent to the consumer.
- Pointers are ADDR_WIDTH bits; full/empty are taken from count, not from pointer compare.
- Internal control states, implemented as an enum: EMPTY (count=0), PARTIAL, FULL.
  - EMPTY->PARTIAL on push.
  - PARTIAL->FULL on push-only at count=2**ADDR_WIDTH-1.
  - FULL->PARTIAL on pop.
  - PARTIAL->EMPTY on pop-only at count=1.
  - The state is consistent with count at all times; assertion in bench.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_WIDTH=8.
  - fifo_state_t enum {EMPTY, PARTIAL, FULL}.
  - Shared baud constants already used by the receiver and transmitter.
- Sub-module uart_fifo_mem holds the storage array: simple dual-port, one synchronous write port, one asynchronous read port, parameterised DATA_WIDTH/ADDR_WIDTH so it infers MLAB/registers.
- Pointer, count and flag logic stays in uart_rx_fifo.

Test Plan:
- Reset then idle: rd_valid=0, count=0, rd_data=8'h00, overflow=0 for 10 cycles.
- Single byte 8'hA5 with wr_stb, rd_ready=0:
  - Next cycle rd_valid=1, rd_data=8'hA5, count=1.
  - Assert rd_ready one cycle: count=0, rd_valid=0.
- Fill with 8'h00..8'h0F, rd_ready=0:
  - almost_full rises when count reaches 12; full=1 at 16.
  - 17th push of 8'hFF: overflow=1, count stays 16.
  - Drain: reads 8'h00..8'h0F in order, with no 8'hFF.
- Full with push and pop in the same cycle (push 8'h55): count stays 16, overflow=0, 8'h55 read last after wrap.
- clr_overflow coincident with a dropped push: overflow remains 1. clr_overflow alone next cycle: overflow=0.
- rst asserted with count=7: next cycle count=0, rd_valid=0. Subsequent push 8'h3C is read as the first byte.
